// File: rtl/karnix_key_pkg.sv
// Shared definitions for the Karnix push-button conditioner:
// hold-FSM state encoding and a constant clog2 for counter widths.
package karnix_key_pkg;

    typedef enum logic [1:0] {
        HOLD_IDLE     = 2'd0,
        HOLD_ARMED    = 2'd1,
        HOLD_FIRE     = 2'd2,
        HOLD_WAIT_REL = 2'd3
    } hold_state_t;

    // Bits needed to count 0..value-1, never less than 1.
    function automatic int kk_clog2(input int unsigned value);
        int unsigned v;
        int          w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/karnix_key_conditioner_chan.sv
// One key channel: 2-FF synchronizer, polarity normalisation,
// debounce counter and press/release pulse generation.
module key_debounce_chan
    import karnix_key_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int DB_CYCLES      = 800000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int   CW       = kk_clog2(DB_CYCLES);
    localparam logic IDLE_PAD = KEY_ACTIVE_LOW;

    logic          sync_q1;
    logic          sync_q2;
    logic          pressed;
    logic          at_limit;
    logic [CW-1:0] cnt_q;

    // Synchronizer parks at the idle pad level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= IDLE_PAD;
            sync_q2 <= IDLE_PAD;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed  = sync_q2 ^ IDLE_PAD;
    assign at_limit = (cnt_q == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (pressed == key_state) begin
                cnt_q <= '0;
            end else if (at_limit) begin
                cnt_q       <= '0;
                key_state   <= pressed;
                key_press   <= pressed;
                key_release <= ~pressed;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/karnix_key_conditioner.sv
// Debounced key levels/pulses for the Murax GPIO port plus a
// long-press reset request on the top key.
module karnix_key_conditioner
    import karnix_key_pkg::*;
#(
    parameter int KEYS           = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int DB_CYCLES      = 800000,
    parameter int HOLD_CYCLES    = 160000000,
    parameter int RST_PULSE      = 16
) (
    input  logic            io_mainClk,
    input  logic            io_asyncReset_n,
    input  logic [KEYS-1:0] io_key,
    output logic [KEYS-1:0] io_keyState,
    output logic [KEYS-1:0] io_keyPress,
    output logic [KEYS-1:0] io_keyRelease,
    output logic            io_holdReset
);

    localparam int HMAX = (HOLD_CYCLES > RST_PULSE) ? HOLD_CYCLES : RST_PULSE;
    localparam int HCW  = kk_clog2(HMAX);

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        key_debounce_chan #(
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
            .DB_CYCLES      (DB_CYCLES)
        ) u_chan (
            .clk         (io_mainClk),
            .rst_n       (io_asyncReset_n),
            .key_raw     (io_key[k]),
            .key_state   (io_keyState[k]),
            .key_press   (io_keyPress[k]),
            .key_release (io_keyRelease[k])
        );
    end

    param_ok : assert property (@(posedge io_mainClk)
        DB_CYCLES >= 2 && HOLD_CYCLES >= 2 && RST_PULSE >= 1);

    hold_state_t    state_q;
    hold_state_t    state_d;
    logic [HCW-1:0] cnt_q;
    logic [HCW-1:0] cnt_d;
    logic           hold_key;

    assign hold_key = io_keyState[KEYS-1];

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            state_q      <= HOLD_IDLE;
            cnt_q        <= '0;
            io_holdReset <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            io_holdReset <= (state_d == HOLD_FIRE);
        end
    end

    // One counter serves both the hold timer and the pulse width.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            HOLD_IDLE: begin
                cnt_d = '0;
                if (hold_key) state_d = HOLD_ARMED;
            end
            HOLD_ARMED: begin
                if (!hold_key) begin
                    state_d = HOLD_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HCW'(HOLD_CYCLES - 1)) begin
                    state_d = HOLD_FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD_FIRE: begin
                if (cnt_q == HCW'(RST_PULSE - 1)) begin
                    state_d = HOLD_WAIT_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD_WAIT_REL: begin
                cnt_d = '0;
                if (!hold_key) state_d = HOLD_IDLE;
            end
            default: begin
                state_d = HOLD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_karnix_key_conditioner.sv
// Self-checking bench for karnix_key_conditioner: directed latency
// checks plus a cycle-level behavioural model under random key activity.
module tb_karnix_key_conditioner;

    localparam int KEYS = 4;
    localparam int DB   = 8;
    localparam int HOLD = 32;
    localparam int RST  = 4;

    logic            clk;
    logic            rst_n;
    logic [KEYS-1:0] io_key;
    logic [KEYS-1:0] key_state;
    logic [KEYS-1:0] key_press;
    logic [KEYS-1:0] key_release;
    logic            hold_reset;

    int n_cmp = 0;
    int n_bad = 0;

    karnix_key_conditioner #(
        .KEYS           (KEYS),
        .KEY_ACTIVE_LOW (1'b1),
        .DB_CYCLES      (DB),
        .HOLD_CYCLES    (HOLD),
        .RST_PULSE      (RST)
    ) dut (
        .io_mainClk      (clk),
        .io_asyncReset_n (rst_n),
        .io_key          (io_key),
        .io_keyState     (key_state),
        .io_keyPress     (key_press),
        .io_keyRelease   (key_release),
        .io_holdReset    (hold_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a key is accepted after its pressed level, seen two
    // edges late, has differed from the accepted level for DB edges in a row.
    // The reset request fires once the accepted top key has been high for
    // HOLD+1 consecutive samples, lasts RST cycles, and re-arms only on release.
    logic [KEYS-1:0] m_p1, m_p2, m_state, m_press, m_rel;
    int              m_run [KEYS];
    logic            m_hold;
    int              m_hlen, m_frem;
    bit              m_fired;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1    <= '1;
            m_p2    <= '1;
            m_state <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_hold  <= 1'b0;
            m_hlen  <= 0;
            m_frem  <= 0;
            m_fired <= 1'b0;
            for (int k = 0; k < KEYS; k++) m_run[k] <= 0;
        end else begin
            automatic logic [KEYS-1:0] seen = ~m_p2;
            automatic logic [KEYS-1:0] ns   = m_state;
            automatic logic [KEYS-1:0] np   = '0;
            automatic logic [KEYS-1:0] nr   = '0;
            automatic int              hl;
            automatic int              fr;
            automatic bit              fd;
            for (int k = 0; k < KEYS; k++) begin
                if (seen[k] != m_state[k]) begin
                    if (m_run[k] + 1 == DB) begin
                        ns[k]    = seen[k];
                        np[k]    = seen[k];
                        nr[k]    = ~seen[k];
                        m_run[k] <= 0;
                    end else begin
                        m_run[k] <= m_run[k] + 1;
                    end
                end else begin
                    m_run[k] <= 0;
                end
            end
            fr = (m_frem > 0) ? m_frem - 1 : 0;
            hl = ns[KEYS-1] ? m_hlen + 1 : 0;
            fd = ns[KEYS-1] ? m_fired : 1'b0;
            if (hl == HOLD + 1 && !fd) begin
                fr = RST;
                fd = 1'b1;
            end
            m_hold  <= (m_frem > 0);
            m_frem  <= fr;
            m_hlen  <= hl;
            m_fired <= fd;
            m_state <= ns;
            m_press <= np;
            m_rel   <= nr;
            m_p2    <= m_p1;
            m_p1    <= io_key;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        io_key = '1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({key_state, key_press, key_release, hold_reset} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {key_state, key_press, key_release, hold_reset});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_state, key_press, key_release, hold_reset} !== 13'd0) begin
                n_bad++;
                $display("FAIL post_reset_quiet t=%0t: got %b want 0", $time,
                         {key_state, key_press, key_release, hold_reset});
            end
        end
    endtask

    task automatic test_press_release();
        @(negedge clk);
        io_key[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_press[0], key_state[0], key_release[0]} !==
                {i == 10, i >= 10, 1'b0}) begin
                n_bad++;
                $display("FAIL press_latency edge=%0d: got p/s/r %b%b%b want %b%b0",
                         i, key_press[0], key_state[0], key_release[0],
                         i == 10, i >= 10);
            end
        end
        @(negedge clk);
        io_key[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_release[0], key_state[0], key_press[0]} !==
                {i == 10, i < 10, 1'b0}) begin
                n_bad++;
                $display("FAIL release_latency edge=%0d: got r/s/p %b%b%b want %b%b0",
                         i, key_release[0], key_state[0], key_press[0],
                         i == 10, i < 10);
            end
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 5; r++) begin
            automatic int w = (r == 0) ? 7 : $urandom_range(1, 7);
            @(negedge clk);
            io_key[1] = 1'b0;
            repeat (w) @(negedge clk);
            io_key[1] = 1'b1;
            repeat (1) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if ({key_state[1], key_press[1], key_release[1]} !== 3'b000) begin
                n_bad++;
                $display("FAIL glitch_rejected rep=%0d: got s/p/r %b%b%b want 000",
                         r, key_state[1], key_press[1], key_release[1]);
            end
        end
        repeat (12) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_state[1], key_press[1], key_release[1]} !== 3'b000) begin
                n_bad++;
                $display("FAIL glitch_tail t=%0t: got s/p/r %b%b%b want 000",
                         $time, key_state[1], key_press[1], key_release[1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        io_key[0] = 1'b0;
        io_key[2] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_press[0], key_press[2]} !== {i == 10, i == 10}) begin
                n_bad++;
                $display("FAIL simultaneous_press edge=%0d: got %b%b want %b%b",
                         i, key_press[0], key_press[2], i == 10, i == 10);
            end
        end
        @(negedge clk);
        io_key[0] = 1'b1;
        io_key[2] = 1'b1;
        repeat (14) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_state, key_press, key_release, hold_reset} !==
                {m_state, m_press, m_rel, m_hold}) begin
                n_bad++;
                $display("FAIL simultaneous_model t=%0t: got %b want %b", $time,
                         {key_state, key_press, key_release, hold_reset},
                         {m_state, m_press, m_rel, m_hold});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < KEYS; k++)
                if ($urandom_range(0, 11) == 0) io_key[k] = ~io_key[k];
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_state, key_press, key_release, hold_reset} !==
                {m_state, m_press, m_rel, m_hold}) begin
                n_bad++;
                $display("FAIL random_model cyc=%0d: got %b want %b", c,
                         {key_state, key_press, key_release, hold_reset},
                         {m_state, m_press, m_rel, m_hold});
            end
        end
        @(negedge clk);
        io_key = '1;
        repeat (60) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_state, key_press, key_release, hold_reset} !==
                {m_state, m_press, m_rel, m_hold}) begin
                n_bad++;
                $display("FAIL random_drain t=%0t: got %b want %b", $time,
                         {key_state, key_press, key_release, hold_reset},
                         {m_state, m_press, m_rel, m_hold});
            end
        end
    endtask

    task automatic test_hold_fire();
        int  j;
        int  w;
        bit  found;
        do_reset();
        @(negedge clk);
        io_key[3] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            found = key_state[3];
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL hold_state_rise: got no rise want rise within 20");
        end
        j = 0;
        do begin
            @(posedge clk);
            #1;
            j++;
        end while (!hold_reset && j < 50);
        n_cmp++;
        if (j !== HOLD + 1) begin
            n_bad++;
            $display("FAIL hold_fire_delay: got %0d want %0d", j, HOLD + 1);
        end
        w = 0;
        while (hold_reset && w < 10) begin
            w++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (w !== RST) begin
            n_bad++;
            $display("FAIL hold_pulse_width: got %0d want %0d", w, RST);
        end
        repeat (100) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({hold_reset, key_state[3]} !== {m_hold, m_state[3]} ||
                hold_reset !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_no_refire t=%0t: got %b want 0", $time,
                         hold_reset);
            end
        end
        @(negedge clk);
        io_key[3] = 1'b1;
        repeat (15) @(posedge clk);
    endtask

    task automatic test_hold_cancel();
        bit found;
        @(negedge clk);
        io_key[3] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            found = key_state[3];
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL cancel_state_rise: got no rise want rise within 20");
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        io_key[3] = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (hold_reset !== 1'b0 ||
                {key_state, key_press, key_release, hold_reset} !==
                {m_state, m_press, m_rel, m_hold}) begin
                n_bad++;
                $display("FAIL hold_cancel t=%0t: got %b want %b", $time,
                         {key_state, key_press, key_release, hold_reset},
                         {m_state, m_press, m_rel, 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid_fire();
        int j;
        bit found;
        @(negedge clk);
        io_key[3] = 1'b0;
        j = 0;
        do begin
            @(posedge clk);
            #1;
            j++;
        end while (!hold_reset && j < 80);
        n_cmp++;
        if (hold_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL fire_reached: got %b want 1", hold_reset);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (hold_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_drop: got %b want 0", hold_reset);
        end
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            found = key_state[3];
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rearm_state_rise: got no rise want rise within 20");
        end
        j = 0;
        do begin
            @(posedge clk);
            #1;
            j++;
        end while (!hold_reset && j < 50);
        n_cmp++;
        if (j !== HOLD + 1) begin
            n_bad++;
            $display("FAIL rearm_fire_delay: got %0d want %0d", j, HOLD + 1);
        end
        @(negedge clk);
        io_key[3] = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({key_state, key_press, key_release, hold_reset} !==
                {m_state, m_press, m_rel, m_hold}) begin
                n_bad++;
                $display("FAIL rearm_model t=%0t: got %b want %b", $time,
                         {key_state, key_press, key_release, hold_reset},
                         {m_state, m_press, m_rel, m_hold});
            end
        end
    endtask

    initial begin
        io_key = '1;
        rst_n  = 1'b0;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_random();
        test_hold_fire();
        test_hold_cancel();
        test_reset_mid_fire();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
